// File: rtl/traffic_pkg.sv
// traffic_pkg: shared bit mappings, channel state encoding and light legality check
package traffic_pkg;
  localparam int NS1 = 0, NS2 = 1, EW1 = 2, EW2 = 3;
  localparam int NS_G = 0, NS_Y = 1, EW_G = 2, EW_Y = 3;
  typedef enum logic [1:0] {IDLE, QUALIFY, LATCHED} chan_state_e;
  // Both directions lit at once, or green and yellow of one direction together.
  function automatic logic light_illegal(input logic [3:0] l);
    return ((l[NS_G] | l[NS_Y]) & (l[EW_G] | l[EW_Y])) | (l[NS_G] & l[NS_Y]) | (l[EW_G] & l[EW_Y]);
  endfunction
endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// traffic_sensor_conditioner_if: detector/controller-side signals of the conditioner
interface traffic_sensor_conditioner_if;
  logic [3:0] raw_sensors;
  logic       raw_emergency;
  logic [3:0] light;
  logic [3:0] traffic_sensors;
  logic       emergency;
  logic       light_fault;
  modport master(output raw_sensors, raw_emergency, light, input traffic_sensors, emergency, light_fault);
  modport slave(input raw_sensors, raw_emergency, light, output traffic_sensors, emergency, light_fault);
endinterface

// File: rtl/sensor_channel.sv
// sensor_channel: debounces one loop detector and holds its demand until served
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic clear,
  output logic demand
);
  localparam int unsigned W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES);
  chan_state_e state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, inc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // IDLE holds cnt at 0, so IDLE and QUALIFY share the same counting rule.
  always_comb begin
    inc     = cnt_q + 1'b1;
    state_d = state_q;
    cnt_d   = '0;
    if (state_q == LATCHED) begin
      state_d = clear ? IDLE : LATCHED;
    end else begin
      state_d = !raw ? IDLE : (inc == LAST ? LATCHED : QUALIFY);
      cnt_d   = (!raw || inc == LAST) ? '0 : inc;
    end
  end
  always_comb demand = state_q == LATCHED;
endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: demand latching, serve timing, emergency debounce
// and illegal-light fail-safe in front of Traffic_Controller.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SERVE_CYCLES    = 8,
  parameter int unsigned EMERG_DEBOUNCE  = 3
) (
  input logic clk,
  input logic reset,
  traffic_sensor_conditioner_if.slave bus
);
  localparam int unsigned SW = $clog2(SERVE_CYCLES + 1);
  localparam int unsigned EW = $clog2(EMERG_DEBOUNCE + 1);
  localparam logic [SW-1:0] SMAX = SW'(SERVE_CYCLES);
  localparam logic [EW-1:0] EMAX = EW'(EMERG_DEBOUNCE);
  logic [SW-1:0] ns_srv_q, ns_srv_d, ew_srv_q, ew_srv_d;
  logic [EW-1:0] em_cnt_q, em_cnt_d, em_inc;
  logic emerg_q, emerg_d, fault_q, fault_d, em_mis, ns_clr, ew_clr;
  logic [3:0] demand;
  // Clear only on the edge the run first reaches SERVE_CYCLES, never while saturated.
  always_comb begin
    ns_srv_d = !bus.light[NS_G] ? '0 : (ns_srv_q == SMAX ? SMAX : ns_srv_q + 1'b1);
    ew_srv_d = !bus.light[EW_G] ? '0 : (ew_srv_q == SMAX ? SMAX : ew_srv_q + 1'b1);
    ns_clr   = ns_srv_d == SMAX && ns_srv_q != SMAX && !fault_q;
    ew_clr   = ew_srv_d == SMAX && ew_srv_q != SMAX && !fault_q;
    em_mis   = bus.raw_emergency != emerg_q;
    em_inc   = em_cnt_q + 1'b1;
    em_cnt_d = (em_mis && em_inc != EMAX) ? em_inc : '0;
    emerg_d  = emerg_q ^ (em_mis && em_inc == EMAX);
    fault_d  = fault_q | light_illegal(bus.light);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ns_srv_q <= '0;
      ew_srv_q <= '0;
      em_cnt_q <= '0;
      emerg_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      ns_srv_q <= ns_srv_d;
      ew_srv_q <= ew_srv_d;
      em_cnt_q <= em_cnt_d;
      emerg_q  <= emerg_d;
      fault_q  <= fault_d;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_ch
    sensor_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.raw_sensors[i]),
      .clear ((i == NS1 || i == NS2) ? ns_clr : ew_clr),
      .demand(demand[i])
    );
  end
  assign bus.traffic_sensors = fault_q ? 4'hF : demand;
  assign bus.emergency       = emerg_q;
  assign bus.light_fault     = fault_q;
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb_traffic_sensor_conditioner: scoreboard bench with a run-length reference model
module tb_traffic_sensor_conditioner;
  localparam int DEB = 4, SRV = 8, EMD = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  traffic_sensor_conditioner_if bus ();
  traffic_sensor_conditioner #(.DEBOUNCE_CYCLES(DEB), .SERVE_CYCLES(SRV), .EMERG_DEBOUNCE(EMD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  logic [5:0] obs;
  assign obs = {bus.traffic_sensors, bus.emergency, bus.light_fault};
  int n_chk = 0, n_fail = 0;
  logic [5:0] q[$];
  int run[4];
  bit lat[4];
  int ns_run, ew_run, mrun;
  bit em, flt;
  logic [3:0] rs = '0, l = '0, lt;
  logic re = 1'b0;
  int hold = 0;

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got ts=%b em=%b flt=%b required ts=%b em=%b flt=%b", nm,
               act[5:2], act[1], act[0], req[5:2], req[1], req[0]);
    end
  endtask

  // Demand = DEB consecutive highs since last release; service = the SRV-th consecutive green.
  task automatic model(input bit r, input logic [3:0] s, input bit e, input logic [3:0] li);
    bit clr_ns, clr_ew, bad;
    logic [5:0] v;
    if (r) begin
      for (int i = 0; i < 4; i++) begin run[i] = 0; lat[i] = 0; end
      ns_run = 0; ew_run = 0; mrun = 0; em = 0; flt = 0;
    end else begin
      ns_run = li[0] ? ns_run + 1 : 0;
      ew_run = li[2] ? ew_run + 1 : 0;
      clr_ns = ns_run == SRV && !flt;
      clr_ew = ew_run == SRV && !flt;
      for (int i = 0; i < 4; i++) begin
        if (lat[i]) begin
          if (i < 2 ? clr_ns : clr_ew) lat[i] = 0;
        end else begin
          run[i] = s[i] ? run[i] + 1 : 0;
          if (run[i] == DEB) begin lat[i] = 1; run[i] = 0; end
        end
      end
      mrun = (e != em) ? mrun + 1 : 0;
      if (mrun == EMD) begin em = !em; mrun = 0; end
      bad = ((li[0] || li[1]) && (li[2] || li[3])) || (li[0] && li[1]) || (li[2] && li[3]);
      flt = flt || bad;
    end
    v = {flt ? 4'hF : {lat[3], lat[2], lat[1], lat[0]}, em, flt};
    q.push_back(v);
  endtask

  task automatic step(input bit r, input logic [3:0] s, input bit e, input logic [3:0] li);
    @(negedge clk);
    reset = r;
    bus.raw_sensors = s;
    bus.raw_emergency = e;
    bus.light = li;
    model(r, s, e, li);
  endtask

  task automatic expect_now(input string nm, input logic [5:0] req);
    @(posedge clk);
    #2;
    chk(nm, obs, req);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) chk("scoreboard", obs, q.pop_front());
  end

  initial begin
    bus.raw_sensors = '0;
    bus.raw_emergency = 1'b0;
    bus.light = '0;
    repeat (2) step(1, 4'hF, 1, 4'h0);
    step(1, 4'hF, 1, 4'h0);
    expect_now("reset_state", 6'b0000_0_0);
    repeat (2) step(0, 4'hF, 1, 4'h0);
    step(0, 4'hF, 1, 4'h0);
    expect_now("edge3_emerg_no_demand", 6'b0000_1_0);
    step(0, 4'hF, 1, 4'h0);
    expect_now("edge4_demand", 6'b1111_1_0);

    repeat (2) step(1, 4'h0, 0, 4'h0);
    repeat (3) step(0, 4'b0100, 0, 4'h0);
    step(0, 4'h0, 0, 4'h0);
    expect_now("short_pulse", 6'b0000_0_0);
    repeat (3) step(0, 4'b0100, 0, 4'h0);
    step(0, 4'b0100, 0, 4'h0);
    expect_now("latch_4th", 6'b0100_0_0);
    repeat (2) step(0, 4'h0, 0, 4'h0);
    expect_now("latch_holds", 6'b0100_0_0);

    repeat (4) step(0, 4'b0001, 0, 4'h0);
    repeat (7) step(0, 4'h0, 0, 4'b0100);
    step(0, 4'h0, 0, 4'b1000);
    expect_now("short_green", 6'b0101_0_0);
    repeat (7) step(0, 4'h0, 0, 4'b0100);
    expect_now("green_7", 6'b0101_0_0);
    step(0, 4'h0, 0, 4'b0100);
    expect_now("green_8_clear", 6'b0001_0_0);

    step(1, 4'h0, 0, 4'h0);
    repeat (4) step(0, 4'b0011, 0, 4'h0);
    expect_now("ns_latched", 6'b0011_0_0);
    repeat (8) step(0, 4'b0011, 0, 4'b0001);
    expect_now("ns_cleared", 6'b0000_0_0);
    repeat (3) step(0, 4'b0011, 0, 4'b0001);
    expect_now("ns_requal_3", 6'b0000_0_0);
    step(0, 4'b0011, 0, 4'b0001);
    expect_now("ns_relatch", 6'b0011_0_0);
    repeat (10) step(0, 4'b0011, 0, 4'b0001);
    expect_now("no_saturated_clear", 6'b0011_0_0);

    step(0, 4'h0, 0, 4'b0101);
    expect_now("fault_set", 6'b1111_0_1);
    repeat (20) step(0, 4'h0, 0, 4'b0001);
    expect_now("fault_sticky", 6'b1111_0_1);
    step(1, 4'h0, 0, 4'h0);
    expect_now("fault_reset", 6'b0000_0_0);

    repeat (2) step(0, 4'h0, 1, 4'h0);
    step(0, 4'h0, 0, 4'h0);
    expect_now("emerg_short", 6'b0000_0_0);
    repeat (2) step(0, 4'h0, 1, 4'h0);
    expect_now("emerg_2", 6'b0000_0_0);
    step(0, 4'h0, 1, 4'h0);
    expect_now("emerg_on", 6'b0000_1_0);
    repeat (2) step(0, 4'h0, 0, 4'h0);
    step(0, 4'h0, 1, 4'h0);
    expect_now("emerg_hold", 6'b0000_1_0);
    repeat (2) step(0, 4'h0, 0, 4'h0);
    expect_now("emerg_off_2", 6'b0000_1_0);
    step(0, 4'h0, 0, 4'h0);
    expect_now("emerg_off", 6'b0000_0_0);

    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) rs[b] = ~rs[b];
      if ($urandom_range(4) == 0) re = ~re;
      if (hold == 0) begin
        case ($urandom_range(4))
          0: l = 4'b0000;
          1: l = 4'b0001;
          2: l = 4'b0010;
          3: l = 4'b0100;
          default: l = 4'b1000;
        endcase
        hold = $urandom_range(12, 1);
      end
      hold--;
      lt = l;
      if ($urandom_range(799) == 0) lt = 4'($urandom_range(15));
      step($urandom_range(249) == 0, rs, re, lt);
    end
    @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
- Sits between the raw intersection detectors and Traffic_Controller; it is the producer side of the controller's `traffic_sensors`/`emergency` inputs and the consumer of its `light` output.
- Debounces the four loop-detector inputs and the emergency preempt input.
- Latches vehicle demand per channel until the controller has served that direction with green for long enough.
- Checks the returned `light` vector for illegal combinations and fails safe when one appears.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive high samples of a raw sensor needed to latch demand (legal range 1..255).
- SERVE_CYCLES, 8: consecutive green cycles for a direction that clear that direction's latched demand (legal range 1..255).
- EMERG_DEBOUNCE, 3: consecutive samples needed to assert or deassert `emergency` (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_sensors  input  4  detector inputs, already synchronised to clk; [3]=EW2, [2]=EW1, [1]=NS2, [0]=NS1.
- raw_emergency  input  1  preempt request, already synchronised to clk.
- light  input  4  from Traffic_Controller; [3]=EW_Y, [2]=EW_G, [1]=NS_Y, [0]=NS_G.
- traffic_sensors  output  4  registered latched demand, same bit mapping as raw_sensors.
- emergency  output  1  registered, debounced preempt.
- light_fault  output  1  registered, sticky illegal-light flag.

Behaviour:
- Clock, reset and output style:
  - One clock domain.
  - Reset is synchronous and active-high, and takes precedence over all other logic.
  - On reset: traffic_sensors=4'b0000, emergency=0, light_fault=0, every channel FSM in IDLE, every counter 0.
  - A reset mid-operation discards any qualify progress and any latched demand.
  - All outputs are registered; there is no combinational path from input to output.
- Channel FSM (one per bit i), states IDLE, QUALIFY, LATCHED:
  - IDLE: if raw_sensors[i]=1, go to QUALIFY with cnt=1. If DEBOUNCE_CYCLES=1, go directly to LATCHED instead.
  - QUALIFY: if raw_sensors[i]=0, go to IDLE with cnt=0. Otherwise increment cnt; when the DEBOUNCE_CYCLES-th consecutive high sample arrives, go to LATCHED.
  - LATCHED: traffic_sensors[i]=1. raw_sensors[i] is ignored. Leave for IDLE when the direction's serve counter reaches SERVE_CYCLES.
  - traffic_sensors[i] is 1 exactly while the channel is in LATCHED, except under fault (see below).
- Latency:
  - traffic_sensors[i] rises on the same edge that samples the DEBOUNCE_CYCLES-th consecutive raw high.
  - A raw pulse shorter than DEBOUNCE_CYCLES never sets demand.
- Serve counters (one NS, driven by light[0]; one EW, driven by light[2]):
  - Count consecutive cycles with that green bit high, saturating at SERVE_CYCLES.
  - Reset to 0 on any cycle where the green bit is low. Yellow does not count.
  - Clear condition: the counter's next value equals SERVE_CYCLES. On that edge, every LATCHED channel of that direction goes to IDLE; NS governs bits [1:0], EW governs bits [3:2].
  - On the clearing cycle, raw input is ignored; re-qualification starts from the following sample.
  - A channel that latches while its direction's counter is already saturated is not cleared until green drops and a new SERVE_CYCLES run completes. This prevents an instant-clear race.
- Emergency:
  - Separate up-counter compares raw_emergency against the current emergency value.
  - Any mismatch increments the counter; any match resets it to 0.
  - emergency toggles on the edge that samples the EMERG_DEBOUNCE-th consecutive mismatch; the counter then resets.
  - Emergency does not alter demand latching.
- Fault detection:
  - Illegal `light`: any NS bit ([1:0]) and any EW bit ([3:2]) high simultaneously, OR G and Y of the same direction high simultaneously.
  - light=4'b0000 is legal (all-red).
  - light_fault sets on the edge after the first illegal sample and stays set until reset.
  - While light_fault=1: traffic_sensors is forced to 4'b1111 and no clearing occurs. Channel FSMs continue to run underneath.
- Width rules:
  - Counters are $clog2(param+1) bits wide.
  - No wrap-around: every counter saturates or is reset before overflow.

Decomposition:
- Shared package traffic_pkg holds:
  - bit-index constants NS1=0, NS2=1, EW1=2, EW2=3 (sensor mapping);
  - NS_G=0, NS_Y=1, EW_G=2, EW_Y=3 (light mapping);
  - the channel state encoding IDLE/QUALIFY/LATCHED.
- Sub-module sensor_channel: one debounce/latch FSM with inputs raw, clear, and output demand. Instantiated four times.
- Top level holds the two serve counters, the emergency debouncer and the fault checker.

Test Plan:
- Reset held 3 cycles with raw_sensors=4'b1111 and raw_emergency=1 -> traffic_sensors=4'b0000, emergency=0, light_fault=0 throughout reset. After release, traffic_sensors=4'b1111 on the 4th edge.
- raw_sensors=4'b0100 high for 3 cycles then low -> traffic_sensors stays 4'b0000. The same input held 4 cycles -> traffic_sensors=4'b0100 on the 4th edge, and it stays set after raw drops.
- With bit 2 latched, light=4'b0100 for 7 cycles then 4'b1000 -> traffic_sensors[2] stays 1. A subsequent run of 8 consecutive cycles of 4'b0100 -> bit 2 clears on the 8th edge, and bit 0 is unaffected.
- NS1 and NS2 both latched, light=4'b0001 for 8 cycles with raw_sensors[1:0] held high -> both bits clear on the 8th edge, then re-latch 4 edges after that.
- light=4'b0101 for 1 cycle -> light_fault=1 on the next edge and traffic_sensors=4'b1111. Both persist with light=4'b0001 for 20 cycles, and return to 0 only after reset.
- raw_emergency high for 2 cycles -> emergency stays 0. High for 3 -> emergency=1 on the 3rd edge. Then low for 2 and high for 1 -> emergency stays 1. Then low for 3 -> emergency=0 on the 3rd edge.
